// File: rtl/rv32_ctrl_pkg.sv
// Shared RV32I control definitions: immediate selector encoding and base opcodes.
// Used by the decode-side selector, the immediate generator and the branch-target unit.
package rv32_ctrl_pkg;

    typedef logic [2:0] imm_sel_t;

    localparam imm_sel_t IMM_R = 3'd0;
    localparam imm_sel_t IMM_I = 3'd1;
    localparam imm_sel_t IMM_S = 3'd2;
    localparam imm_sel_t IMM_B = 3'd3;
    localparam imm_sel_t IMM_U = 3'd4;
    localparam imm_sel_t IMM_J = 3'd5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Selector codes above IMM_J have no immediate format.
    function automatic logic isUndefSel(input imm_sel_t sel);
        return (sel > IMM_J);
    endfunction

endpackage

// File: rtl/imm_extend.sv
// Purely combinational RV32I immediate extraction and sign extension.
// Shared between the ID immediate stage and the branch-target unit.
module imm_extend
    import rv32_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_sel_t    sel,
    output logic [31:0] imm
);

    // Opcode bits never contribute to an immediate.
    logic unusedOpcode_s;
    assign unusedOpcode_s = ^instr[6:0];

    // Immediate format decode; R-type and undefined selectors give zero.
    always_comb begin
        imm = 32'h0000_0000;
        case (sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// ID/EX immediate stage: generates the immediate on entry and buffers it behind a
// main output register plus a one-entry skid. Optional macro: IMMGEN_ILLEGAL_EN.
module imm_gen_stage
    import rv32_ctrl_pkg::*;
#(
    parameter int TAG_W = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_imm,
    output logic [SEL_W-1:0] out_sel,
    output logic [TAG_W-1:0] out_tag,
`ifdef IMMGEN_ILLEGAL_EN
    output logic             out_illegal,
`endif
    input  logic             flush
);

    logic [31:0]      newImm_s;
    logic             accept_s;
    logic             mainFree_s;
    logic             mainLoadSkid_s;
    logic             mainLoadIn_s;
    logic             skidLoadIn_s;
    logic             mainValidNext_s;
    logic             skidValidNext_s;

    logic             skidValid_r;
    logic [31:0]      skidImm_r;
    logic [SEL_W-1:0] skidSel_r;
    logic [TAG_W-1:0] skidTag_r;

    imm_extend u_immExtend (
        .instr (in_instr),
        .sel   (imm_sel_t'(in_sel)),
        .imm   (newImm_s)
    );

    assign accept_s   = in_valid && in_ready;
    assign mainFree_s = !out_valid || out_ready;

    // Steering: main refills from skid first so ordering stays FIFO; flush kills both.
    always_comb begin
        mainLoadSkid_s  = 1'b0;
        mainLoadIn_s    = 1'b0;
        skidLoadIn_s    = 1'b0;
        mainValidNext_s = out_valid;
        skidValidNext_s = skidValid_r;
        if (flush) begin
            mainValidNext_s = 1'b0;
            skidValidNext_s = 1'b0;
        end else if (mainFree_s) begin
            if (skidValid_r) begin
                mainLoadSkid_s  = 1'b1;
                mainValidNext_s = 1'b1;
                skidLoadIn_s    = accept_s;
                skidValidNext_s = accept_s;
            end else begin
                mainLoadIn_s    = accept_s;
                mainValidNext_s = accept_s;
                skidValidNext_s = 1'b0;
            end
        end else begin
            skidLoadIn_s    = accept_s;
            skidValidNext_s = skidValid_r || accept_s;
        end
    end

    // Main output register; data is held untouched while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_imm   <= 32'h0000_0000;
            out_sel   <= '0;
            out_tag   <= '0;
        end else begin
            out_valid <= mainValidNext_s;
            if (mainLoadSkid_s) begin
                out_imm <= skidImm_r;
                out_sel <= skidSel_r;
                out_tag <= skidTag_r;
            end else if (mainLoadIn_s) begin
                out_imm <= newImm_s;
                out_sel <= in_sel;
                out_tag <= in_tag;
            end
        end
    end

    // Skid register and the registered ready that mirrors its emptiness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skidValid_r <= 1'b0;
            in_ready    <= 1'b1;
            skidImm_r   <= 32'h0000_0000;
            skidSel_r   <= '0;
            skidTag_r   <= '0;
        end else begin
            skidValid_r <= skidValidNext_s;
            in_ready    <= !skidValidNext_s;
            if (skidLoadIn_s) begin
                skidImm_r <= newImm_s;
                skidSel_r <= in_sel;
                skidTag_r <= in_tag;
            end
        end
    end

`ifdef IMMGEN_ILLEGAL_EN
    logic newIll_s;
    logic skidIll_r;

    assign newIll_s = isUndefSel(imm_sel_t'(in_sel)) || (in_instr[1:0] != 2'b11);

    // Illegal flag travels with its entry through the same steering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_illegal <= 1'b0;
            skidIll_r   <= 1'b0;
        end else begin
            if (flush) begin
                out_illegal <= 1'b0;
                skidIll_r   <= 1'b0;
            end else begin
                if (mainLoadSkid_s) begin
                    out_illegal <= skidIll_r;
                end else if (mainLoadIn_s) begin
                    out_illegal <= newIll_s;
                end
                if (skidLoadIn_s) begin
                    skidIll_r <= newIll_s;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: directed scenarios plus random traffic
// scored against a queue-based reference model.
module tb_imm_gen_stage;

    localparam int TAG_W = 32;
    localparam int SEL_W = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [SEL_W-1:0] in_sel;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_imm;
    logic [SEL_W-1:0] out_sel;
    logic [TAG_W-1:0] out_tag;
    logic             flush;
`ifdef IMMGEN_ILLEGAL_EN
    logic             out_illegal;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] imm;
        logic [2:0]  sel;
        logic [31:0] tag;
        logic        ill;
    } ent_t;

    ent_t q[$];

    imm_gen_stage #(.TAG_W(TAG_W), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_sel      (in_sel),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_sel     (out_sel),
        .out_tag     (out_tag),
`ifdef IMMGEN_ILLEGAL_EN
        .out_illegal (out_illegal),
`endif
        .flush       (flush)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Immediate value from the format rules, built with shifts and masks on the word.
    function automatic logic [31:0] refImm(input logic [31:0] i, input logic [2:0] sel);
        logic [31:0] sx;
        sx = i[31] ? 32'hFFFF_FFFF : 32'h0;
        case (sel)
            3'd1:    return (sx << 12) | (i >> 20);
            3'd2:    return (sx << 12) | ((i >> 25) << 5) | ((i >> 7) & 32'h1F);
            3'd3:    return (sx << 12) | (((i >> 7) & 32'h1) << 11) | (((i >> 25) & 32'h3F) << 5)
                            | (((i >> 8) & 32'hF) << 1);
            3'd4:    return i & 32'hFFFF_F000;
            3'd5:    return (sx << 20) | (((i >> 12) & 32'hFF) << 12) | (((i >> 20) & 32'h1) << 11)
                            | (((i >> 21) & 32'h3FF) << 1);
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] s,
                         input logic [31:0] t, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_sel    = s;
        in_tag    = t;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Check outputs against the model, advance the model for this edge, then clock.
    task automatic tick();
        ent_t e;
        logic acc;
        logic drn;
        check("valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(q.size() < 2));
        if (q.size() != 0) begin
            check("imm", out_imm, q[0].imm);
            check("sel", 32'(out_sel), 32'(q[0].sel));
            check("tag", out_tag, q[0].tag);
`ifdef IMMGEN_ILLEGAL_EN
            check("illegal", 32'(out_illegal), 32'(q[0].ill));
`endif
        end
        acc = in_valid && (q.size() < 2);
        drn = (q.size() != 0) && out_ready;
        e.imm = refImm(in_instr, in_sel);
        e.sel = in_sel;
        e.tag = in_tag;
        e.ill = (in_sel >= 3'd6) || (in_instr[1:0] != 2'b11);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    logic [31:0] b2bInstr [5] = '{32'h0011_2623, 32'hFE00_0EE3, 32'h1234_50B7, 32'h0080_006F, 32'h0020_81B3};
    logic [2:0]  b2bSel   [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [31:0] b2bExp   [5] = '{32'h0000_000C, 32'hFFFF_FFFC, 32'h1234_5000, 32'h0000_0008, 32'h0000_0000};

    initial begin
        logic [31:0] r;
        rst = 1'b1;
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_imm", out_imm, 32'd0);
        check("rst_sel", 32'(out_sel), 32'd0);
        check("rst_tag", out_tag, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // addi x1, x0, -1
        drive(1'b1, 32'hFFF0_0093, 3'd1, 32'h1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_imm", out_imm, 32'hFFFF_FFFF);
        tick();

        for (int k = 0; k < 5; k++) begin
            drive(1'b1, b2bInstr[k], b2bSel[k], 32'h10 + 32'(k), 1'b1, 1'b0);
            tick();
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_imm", out_imm, b2bExp[k]);
        end
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();

        // Backpressure: two entries stack up behind a stalled output.
        drive(1'b1, 32'h0011_2623, 3'd2, 32'hA, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hFE00_0EE3, 3'd3, 32'hB, 1'b0, 1'b0);
        tick();
        check("bp_ready_low", 32'(in_ready), 32'd0);
        check("bp_hold_a", out_tag, 32'hA);
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0);
        tick();
        check("bp_hold_a2", out_tag, 32'hA);
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        check("bp_then_b", out_tag, 32'hB);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Flush with both slots full and a same-cycle offer.
        drive(1'b1, 32'h1234_50B7, 3'd4, 32'h21, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0080_006F, 3'd5, 32'h22, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hFFF0_0093, 3'd1, 32'h23, 1'b1, 1'b1);
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        check("flush_not_captured", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle while stalled and full.
        drive(1'b1, 32'h1234_50B7, 3'd4, 32'h31, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h0011_2623, 3'd2, 32'h32, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        check("arst_imm", out_imm, 32'd0);
        check("arst_sel", 32'(out_sel), 32'd0);
        check("arst_tag", out_tag, 32'd0);
        q.delete();
        #2;
        rst = 1'b0;
        drive(1'b1, 32'hFFF0_0093, 3'd1, 32'h33, 1'b1, 1'b0);
        tick();
        check("arst_after_valid", 32'(out_valid), 32'd1);
        check("arst_after_tag", out_tag, 32'h33);
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();

        // Undefined selector and non-32-bit encoding.
        drive(1'b1, 32'hFFF0_0093, 3'd6, 32'h41, 1'b1, 1'b0);
        tick();
        check("sel6_imm", out_imm, 32'd0);
`ifdef IMMGEN_ILLEGAL_EN
        check("sel6_illegal", 32'(out_illegal), 32'd1);
`endif
        drive(1'b1, 32'h0000_0000, 3'd1, 32'h42, 1'b1, 1'b0);
        tick();
        check("zero_imm", out_imm, 32'd0);
`ifdef IMMGEN_ILLEGAL_EN
        check("zero_illegal", 32'(out_illegal), 32'd1);
`endif
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            r = $urandom();
            if ($urandom_range(0, 7) != 0) r[1:0] = 2'b11;
            drive(($urandom() % 4) != 0, r, 3'($urandom_range(0, 7)), $urandom(),
                  ($urandom() % 4) != 0, ($urandom() % 32) == 0);
            tick();
        end
        drive(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
